lsu_ctrl: RTL and testbench

Multi-cycle load/store sequencer for the RV32I core. It accepts one decoded LOAD/STORE operation at a time and checks alignment. It drives a single-outstanding memory request/grant/response handshake, then returns lane-formatted, sign- or zero-extended load data for writeback, or a precise exception. It sits between decode/ALU (address = rs1+imm) and the data-memory port.

---
 rtl/lsu_ctrl.sv | 223 ++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store sequencer for the RV32I core.
// Takes one decoded LOAD/STORE at a time and checks its alignment.
// It then drives a single-outstanding req/gnt/rvalid memory handshake.
// When the access ends it returns formatted load data or a precise exception.
module lsu_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        done,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        exc,
  output logic [3:0]  exc_cause,
  output logic [31:0] exc_tval
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // The counter only has to reach TIMEOUT-1. The timeout fires at the end of that cycle.
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [3:0] CAUSE_LD_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_LD_FAULT    = 4'd5;
  localparam logic [3:0] CAUSE_ST_MISALIGN = 4'd6;
  localparam logic [3:0] CAUSE_ST_FAULT    = 4'd7;

  logic [1:0]    state_reg, state_next;
  logic          load_reg;
  logic [2:0]    funct3_reg;
  logic [31:0]   addr_reg;
  logic [31:0]   sdata_reg;
  logic [4:0]    rd_reg;
  logic [CW-1:0] cnt_reg;
  logic          exc_reg;
  logic [4:0]    wb_rd_reg;
  logic [31:0]   wb_data_reg;
  logic [3:0]    exc_cause_reg;
  logic [31:0]   exc_tval_reg;

  logic          f3_ok;
  logic          legal;
  logic          misaligned;
  logic          to_hit;
  logic          complete_now;
  logic          fault_now;
  logic [1:0]    off;
  logic [3:0]    be_fmt;
  logic [31:0]   wdata_fmt;
  logic [7:0]    rbyte [4];
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_fmt;

  // Issue decode. This checks that funct3 is valid for the class, that the class is exactly one of load/store, and that the access is aligned.
  always_comb begin
    f3_ok = 1'b0;
    if (is_load)
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else
      f3_ok = funct3 inside {3'b000, 3'b001, 3'b010};
    legal      = start & (is_load ^ is_store) & f3_ok;
    misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                 ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  end

  // The timeout is reached when the count hits its last value. It is disabled when TIMEOUT is 0.
  always_comb begin
    to_hit       = (TIMEOUT != 0) && (cnt_reg == TO_LAST);
    complete_now = (state_reg == WAIT) & mem_rvalid;
    fault_now    = to_hit & (((state_reg == REQ) & ~mem_gnt) |
                             ((state_reg == WAIT) & ~mem_rvalid));
  end

  // Store lane steering, based on the latched width and byte offset.
  always_comb begin
    off       = addr_reg[1:0];
    be_fmt    = 4'b1111;
    wdata_fmt = sdata_reg;
    case (funct3_reg[1:0])
      2'b00: begin
        be_fmt    = 4'b0001 << off;
        wdata_fmt = {4{sdata_reg[7:0]}};
      end
      2'b01: begin
        be_fmt    = 4'b0011 << off;
        wdata_fmt = {2{sdata_reg[15:0]}};
      end
      default: begin
        be_fmt    = 4'b1111;
        wdata_fmt = sdata_reg;
      end
    endcase
  end

  // Split the response word into byte lanes for byte-load selection.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_rbyte
      assign rbyte[gi] = mem_rdata[8*gi +: 8];
    end
  endgenerate

  // Load formatting. It selects a byte or halfword lane, then sign- or zero-extends it.
  always_comb begin
    ld_byte = rbyte[off];
    ld_half = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_reg)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'd0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'd0, ld_half};
      default: ld_fmt = mem_rdata;
    endcase
  end

  // Sequencer next-state logic. A grant beats a timeout in REQ, and a response beats a timeout in WAIT.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (legal)
          state_next = misaligned ? DONE : REQ;
      end
      REQ: begin
        if (mem_gnt)
          state_next = WAIT;
        else if (to_hit)
          state_next = DONE;
      end
      WAIT: begin
        if (mem_rvalid || to_hit)
          state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State, latched operation, timeout counter and held result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      load_reg      <= 1'b0;
      funct3_reg    <= 3'd0;
      addr_reg      <= 32'd0;
      sdata_reg     <= 32'd0;
      rd_reg        <= 5'd0;
      cnt_reg       <= '0;
      exc_reg       <= 1'b0;
      wb_rd_reg     <= 5'd0;
      wb_data_reg   <= 32'd0;
      exc_cause_reg <= 4'd0;
      exc_tval_reg  <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && legal) begin
        load_reg   <= is_load;
        funct3_reg <= funct3;
        addr_reg   <= addr;
        sdata_reg  <= store_data;
        rd_reg     <= rd;
        cnt_reg    <= '0;
        exc_reg    <= misaligned;
        if (misaligned) begin
          wb_rd_reg     <= rd;
          exc_cause_reg <= is_load ? CAUSE_LD_MISALIGN : CAUSE_ST_MISALIGN;
          exc_tval_reg  <= addr;
        end
      end
      if ((state_reg == REQ || state_reg == WAIT) && cnt_reg != TO_LAST)
        cnt_reg <= cnt_reg + 1'b1;
      if (complete_now) begin
        exc_reg   <= 1'b0;
        wb_rd_reg <= rd_reg;
        if (load_reg)
          wb_data_reg <= ld_fmt;
      end else if (fault_now) begin
        exc_reg       <= 1'b1;
        wb_rd_reg     <= rd_reg;
        exc_cause_reg <= load_reg ? CAUSE_LD_FAULT : CAUSE_ST_FAULT;
        exc_tval_reg  <= addr_reg;
      end
    end
  end

  // Output decode. The memory port is driven only while the request is open.
  always_comb begin
    busy      = (state_reg != IDLE);
    mem_req   = (state_reg == REQ);
    mem_we    = mem_req & ~load_reg;
    mem_addr  = mem_req ? {addr_reg[31:2], 2'b00} : 32'd0;
    mem_be    = mem_req ? be_fmt : 4'd0;
    mem_wdata = mem_req ? wdata_fmt : 32'd0;
    done      = (state_reg == DONE);
    exc       = done & exc_reg;
    wb_valid  = done & load_reg & ~exc_reg;
    wb_rd     = wb_rd_reg;
    wb_data   = wb_data_reg;
    exc_cause = exc_cause_reg;
    exc_tval  = exc_tval_reg;
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: self-checking bench for lsu_ctrl.
// Runs directed and randomized transactions against a behavioural model of the load/store sequencer.
module tb_lsu_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        done;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc;
  logic [3:0]  exc_cause;
  logic [31:0] exc_tval;

  int n_tests = 0;
  int n_fail  = 0;

  lsu_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .is_store(is_store),
    .funct3(funct3), .addr(addr), .store_data(store_data), .rd(rd),
    .busy(busy), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .done(done),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .exc(exc),
    .exc_cause(exc_cause), .exc_tval(exc_tval)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_req"}, mem_req, 0);
    chk({tag, "_we"}, mem_we, 0);
    chk({tag, "_maddr"}, mem_addr, 0);
    chk({tag, "_be"}, mem_be, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_wbv"}, wb_valid, 0);
    chk({tag, "_wbrd"}, wb_rd, 0);
    chk({tag, "_wbdata"}, wb_data, 0);
    chk({tag, "_exc"}, exc, 0);
    chk({tag, "_cause"}, exc_cause, 0);
    chk({tag, "_tval"}, exc_tval, 0);
  endtask

  // Drive junk start requests while the unit is busy. All of them must be ignored.
  task automatic drive_noise(input bit noise);
    if (noise) begin
      start      = 1'b1;
      is_load    = 1'b1;
      is_store   = 1'b0;
      funct3     = 3'b010;
      addr       = $urandom & 32'hFFFF_FFFC;
      store_data = $urandom;
      rd         = 5'($urandom);
    end else begin
      start = 1'b0;
    end
  endtask

  // One transaction: issue, act as the memory with gd grant waits and rl response waits, then check the result against the model.
  task automatic do_op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [4:0] r, input int gd,
                       input int rl, input logic [31:0] rdata, input bit noise);
    int          size;
    int          off;
    bit          mis;
    logic [31:0] mask;
    logic [31:0] exp_val;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = int'(a[1:0]);
    mis  = (a % size) != 0;
    mask = (size == 1) ? 32'hFF : (size == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
    exp_be = 4'((((1 << size) - 1) << off) & 15);
    exp_wd = (size == 1) ? sd[7:0] * 32'h0101_0101 :
             (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    exp_val = (rdata >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && exp_val[8*size-1])
      exp_val = exp_val | ~mask;

    start = 1'b1; is_load = ld; is_store = !ld; funct3 = f3;
    addr = a; store_data = sd; rd = r;
    tick();
    drive_noise(noise);
    if (mis) begin
      $display("[TB] op ld=%0d f3=%0d addr=%h misaligned", ld, f3, a);
      chk("mis_done", done, 1);
      chk("mis_exc", exc, 1);
      chk("mis_cause", exc_cause, ld ? 4 : 6);
      chk("mis_tval", exc_tval, a);
      chk("mis_req", mem_req, 0);
      chk("mis_wbv", wb_valid, 0);
      tick();
      start = 1'b0;
      chk("mis_idle", busy, 0);
      return;
    end
    for (int i = 0; i <= gd; i++) begin
      chk("req", mem_req, 1);
      chk("req_we", mem_we, !ld);
      chk("req_addr", mem_addr, {a[31:2], 2'b00});
      chk("req_be", mem_be, exp_be);
      chk("req_wdata", mem_wdata, exp_wd);
      chk("req_done", done, 0);
      mem_gnt = (i == gd);
      tick();
      drive_noise(noise);
    end
    mem_gnt = 1'b0;
    for (int j = 0; j <= rl; j++) begin
      chk("wait_req", mem_req, 0);
      chk("wait_busy", busy, 1);
      chk("wait_done", done, 0);
      mem_rvalid = (j == rl);
      mem_rdata  = (j == rl) ? rdata : $urandom;
      tick();
      drive_noise(noise);
    end
    mem_rvalid = 1'b0;
    $display("[TB] op ld=%0d f3=%0d addr=%h gd=%0d rl=%0d wb_data=%h exp=%h",
             ld, f3, a, gd, rl, wb_data, exp_val);
    chk("done", done, 1);
    chk("done_exc", exc, 0);
    chk("done_wbv", wb_valid, ld);
    if (ld) begin
      chk("wb_data", wb_data, exp_val);
      chk("wb_rd", wb_rd, r);
    end
    tick();
    start = 1'b0;
    chk("after_idle", busy, 0);
    chk("after_done", done, 0);
  endtask

  // Issue an aligned word access that is never granted. It must be abandoned after TO cycles.
  task automatic do_timeout(input bit ld, input logic [31:0] a);
    int cycles;
    start = 1'b1; is_load = ld; is_store = !ld; funct3 = 3'b010;
    addr = a; store_data = $urandom; rd = 5'd9;
    tick();
    start = 1'b0;
    cycles = 0;
    while (mem_req && cycles < 40) begin
      cycles++;
      tick();
    end
    $display("[TB] timeout ld=%0d addr=%h req_cycles=%0d", ld, a, cycles);
    chk("to_cycles", cycles, TO);
    chk("to_done", done, 1);
    chk("to_exc", exc, 1);
    chk("to_cause", exc_cause, ld ? 5 : 7);
    chk("to_tval", exc_tval, a);
    chk("to_wbv", wb_valid, 0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_rvalid = 1'b0;
    chk("to_stray_busy", busy, 0);
    chk("to_stray_done", done, 0);
    chk("to_stray_wbv", wb_valid, 0);
  endtask

  task automatic do_illegal(input bit ld, input bit st, input logic [2:0] f3);
    start = 1'b1; is_load = ld; is_store = st; funct3 = f3;
    addr = 32'h0000_4000; store_data = 32'h0; rd = 5'd3;
    tick();
    start = 1'b0;
    $display("[TB] illegal ld=%0d st=%0d f3=%0d busy=%0d", ld, st, f3, busy);
    chk("ill_busy", busy, 0);
    chk("ill_req", mem_req, 0);
    chk("ill_done", done, 0);
    tick();
    chk("ill_done2", done, 0);
  endtask

  initial begin
    logic [2:0] ld_f3 [5];
    logic [2:0] st_f3 [3];
    ld_f3[0] = 3'b000; ld_f3[1] = 3'b001; ld_f3[2] = 3'b010;
    ld_f3[3] = 3'b100; ld_f3[4] = 3'b101;
    st_f3[0] = 3'b000; st_f3[1] = 3'b001; st_f3[2] = 3'b010;

    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'd0;
    addr = 32'd0; store_data = 32'd0; rd = 5'd0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    #2;
    chk_all_zero("reset");
    tick(); tick();
    rst = 1'b0;
    tick();

    do_op(1, 3'b010, 32'h0000_1000, 32'h0, 5'd1, 0, 0, 32'hDEAD_BEEF, 0);
    chk("lw_lit", wb_data, 32'hDEAD_BEEF);
    do_op(1, 3'b000, 32'h0000_1003, 32'h0, 5'd2, 0, 0, 32'h80FF_FFFF, 0);
    chk("lb_lit", wb_data, 32'hFFFF_FF80);
    do_op(1, 3'b100, 32'h0000_1003, 32'h0, 5'd3, 0, 0, 32'h80FF_FFFF, 0);
    chk("lbu_lit", wb_data, 32'h0000_0080);
    do_op(1, 3'b101, 32'h0000_1002, 32'h0, 5'd4, 1, 1, 32'hBEEF_1234, 0);
    chk("lhu_lit", wb_data, 32'h0000_BEEF);
    do_op(0, 3'b000, 32'h0000_2001, 32'h0000_00A5, 5'd5, 3, 0, 32'h0, 0);
    do_op(1, 3'b001, 32'h0000_3001, 32'h0, 5'd6, 0, 0, 32'h0, 0);
    do_op(0, 3'b010, 32'h0000_3002, 32'h0, 5'd7, 0, 0, 32'h0, 0);
    // Longest completing access: its response lands on the final cycle before timeout.
    do_op(1, 3'b010, 32'h0000_5000, 32'h0, 5'd8, 3, 3, 32'hCAFE_F00D, 1);

    do_timeout(1, 32'h0000_6000);
    do_timeout(0, 32'h0000_6004);

    do_illegal(1, 1, 3'b010);
    do_illegal(0, 0, 3'b010);
    do_illegal(1, 0, 3'b011);
    do_illegal(0, 1, 3'b100);
    do_illegal(1, 0, 3'b110);

    // Asynchronous reset while waiting for a response.
    start = 1'b1; is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010;
    addr = 32'h0000_7000; rd = 5'd10;
    tick();
    start = 1'b0;
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    chk("rst_wait_busy", busy, 1);
    #2 rst = 1'b1;
    #1 chk_all_zero("rst_async");
    #2 rst = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hAAAA_5555;
    tick();
    mem_rvalid = 1'b0;
    $display("[TB] reset-in-wait then stray rvalid busy=%0d done=%0d", busy, done);
    chk("rst_stray_busy", busy, 0);
    chk("rst_stray_done", done, 0);
    chk("rst_stray_wbdata", wb_data, 0);
    tick();

    for (int k = 0; k < 60; k++) begin
      bit          ld;
      logic [2:0]  f3;
      ld = 1'($urandom_range(0, 1));
      f3 = ld ? ld_f3[$urandom_range(0, 4)] : st_f3[$urandom_range(0, 2)];
      do_op(ld, f3, $urandom, $urandom, 5'($urandom), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom, ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
